bn_slice_subtractor: RTL and testbench
======================================

// Module: bN_slice_subtractor
// PURPOSE
//   Multi-cycle N-bit subtractor: Z = X - Y - B_in, one 4-bit slice per clock, LSB slice first.
//   Borrow is registered between slices.
//   Valid/ready handshake on both input and output sides.
//   Subtraction-side companion to the CLA adder blocks; used where a registered, area-light
//   subtract/compare path is needed in the ALU datapath.
// PARAMETERS
//   N   16   total operand width in bits; must be a multiple of 4 and >= 8 (elaboration error otherwise)
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   rst_n      in   1    synchronous reset, active-low
//   in_valid   in   1    X, Y and B_in are valid this cycle
//   in_ready   out  1    block can accept an operation (high only in IDLE)
//   X          in   N    minuend
//   Y          in   N    subtrahend
//   B_in       in   1    borrow in
//   out_valid  out  1    Z, B_out and overflow are valid (high only in DONE)
//   out_ready  in   1    consumer accepts the result
//   Z          out  N    difference, X - Y - B_in mod 2^N
//   B_out      out  1    unsigned borrow out; 1 iff X < Y + B_in (unsigned)
//   overflow   out  1    two's-complement overflow of the signed subtraction
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge), taking priority over everything:
//     state=IDLE, slice counter=0, borrow reg=0, Z=0, B_out=0, overflow=0, out_valid=0, in_ready=1.
//     Reset in BUSY or DONE discards the partial or pending result.
//   States:
//     IDLE: in_ready=1, out_valid=0.
//       On in_valid && in_ready: latch X, Y; borrow reg <= B_in; cnt <= 0; Z <= 0; go to BUSY.
//     BUSY: in_ready=0. Each cycle, for slice k=cnt:
//       {c, d} = X[4k+3:4k] + ~Y[4k+3:4k] + !borrow   (5-bit sum)
//       Z[4k+3:4k] <= d; borrow <= !c; cnt <= cnt+1.
//       When cnt == N/4-1, after processing that slice:
//         B_out <= !c;
//         overflow <= (Xs != Ys) && (d[3] != Xs), where Xs, Ys are the latched sign bits;
//         go to DONE.
//     DONE: out_valid=1. Z, B_out and overflow are held stable.
//       On out_ready: go to IDLE. Outputs keep their values; only out_valid drops.
//   Latency: accept at edge E -> out_valid high after edge E+N/4 (4 cycles for N=16).
//   Throughput: min N/4+2 cycles per operation; no accept in the same cycle as a result handoff.
//   in_valid while in_ready=0 is ignored, and X/Y changes during BUSY have no effect (operands latched).
//   out_ready while out_valid=0 is ignored.
//   Slice counter width: clog2(N/4); it never wraps past N/4-1.
// TESTING (N=16; check each case for Z, B_out and overflow)
//   1. X=0x1234, Y=0x0034, B_in=0
//      -> Z=0x1200, B_out=0, ov=0; out_valid exactly 4 cycles after accept.
//   2. X=0x0000, Y=0x0001, B_in=0 -> Z=0xFFFF, B_out=1, ov=0 (borrow ripples through all slices).
//      X=0x0005, Y=0x0005, B_in=1 -> Z=0xFFFF, B_out=1, ov=0.
//   3. X=0x8000, Y=0x0001, B_in=0 -> Z=0x7FFF, B_out=0, ov=1.
//      X=0x7FFF, Y=0xFFFF, B_in=0 -> Z=0x8000, B_out=1, ov=1.
//   4. Backpressure: out_ready low 3 cycles in DONE
//      -> out_valid, Z, B_out and ov stable; in_ready=0.
//      An in_valid pulse during that time is not accepted.
//      Raise out_ready -> IDLE, in_ready=1 next cycle.
//   5. rst_n=0 during BUSY cycle 2 -> next edge: IDLE, in_ready=1, out_valid=0, Z=0, B_out=0, ov=0.
//      A following op (0x00FF - 0x000F) -> Z=0x00F0.
//   6. Random: 1000 ops with random out_ready stalls; compare against a behavioural X-Y-B_in model.

Source files
------------

// File: rtl/bn_slice_subtractor.sv
// Multi-cycle N-bit subtractor, one 4-bit slice per clock, LSB first.
// Borrow is registered between slices; valid/ready on both sides.
module bn_slice_subtractor #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         B_out,
  output logic         overflow
);

  localparam int S  = N / 4;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  if ((N % 4) != 0 || N < 8) begin : g_chk
    $error("bn_slice_subtractor: N must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;
  logic [N-1:0]  r_z;
  logic          r_bout;
  logic          r_ov;

  logic [CW+1:0] w_sh;
  logic [N-1:0]  w_xsh;
  logic [N-1:0]  w_ysh;
  logic [3:0]    w_xs;
  logic [3:0]    w_ys;
  logic [4:0]    w_sum;
  logic [N-1:0]  w_dpos;
  logic          w_ovf;

  assign w_sh   = {r_cnt, 2'b00};
  assign w_xsh  = r_x >> w_sh;
  assign w_ysh  = r_y >> w_sh;
  assign w_xs   = w_xsh[3:0];
  assign w_ys   = w_ysh[3:0];
  // Subtract as X + ~Y + carry, where carry is the inverted borrow
  assign w_sum  = {1'b0, w_xs} + {1'b0, ~w_ys}
                + {4'b0000, ~r_borrow};
  assign w_dpos = {{(N-4){1'b0}}, w_sum[3:0]} << w_sh;
  assign w_ovf  = (r_x[N-1] != r_y[N-1])
               && (w_sum[3] != r_x[N-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_bout   <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x      <= X;
            r_y      <= Y;
            r_borrow <= B_in;
            r_cnt    <= '0;
            r_z      <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_z      <= r_z | w_dpos;
          r_borrow <= ~w_sum[4];
          if (r_cnt == LAST) begin
            r_bout  <= ~w_sum[4];
            r_ov    <= w_ovf;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Z         = r_z;
  assign B_out     = r_bout;
  assign overflow  = r_ov;

endmodule

// File: tb/tb_bn_slice_subtractor.sv
// Self-checking bench for bn_slice_subtractor (N=16).
// Directed cases plus randomized ops against an arithmetic model.
module tb_bn_slice_subtractor;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         B_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Z;
  logic         B_out;
  logic         overflow;

  int checks;
  int failures;

  bn_slice_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .B_in     (B_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .B_out    (B_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        b,
    output logic [15:0] ez,
    output logic        eb,
    output logic        eov
  );
    int d;
    int sd;
    d   = int'(x) - int'(y) - int'(b);
    sd  = int'($signed(x)) - int'($signed(y)) - int'(b);
    ez  = d[15:0];
    eb  = (d < 0);
    eov = (sd > 32767) || (sd < -32768);
  endtask

  // Accept an op, wait for out_valid, check, stall, hand off
  task automatic run_op(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        b,
    input int          stall,
    input string       nm
  );
    logic [15:0] ez;
    logic        eb;
    logic        eov;
    int          lat;
    model(x, y, b, ez, eb, eov);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready got=%b exp=1", nm, in_ready);
    end
    in_valid = 1'b1;
    X = x;
    Y = y;
    B_in = b;
    tick();
    in_valid = 1'b0;
    X = 16'($urandom);
    Y = 16'($urandom);
    B_in = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=4", nm, lat);
      return;
    end
    checks++;
    if (Z !== ez || B_out !== eb || overflow !== eov) begin
      failures++;
      $display("FAIL %s result got=%h/%b/%b exp=%h/%b/%b",
               nm, Z, B_out, overflow, ez, eb, eov);
    end
    for (int i = 0; i < stall; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Z !== ez) begin
      failures++;
      $display("FAIL %s handoff got=%b/%b/%h exp=0/1/%h",
               nm, out_valid, in_ready, Z, ez);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Z !== 16'h0
        || B_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset got=%b/%b/%h/%b/%b exp=1/0/0000/0/0",
               in_ready, out_valid, Z, B_out, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h0034, 1'b0, 0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, 1, "ripple");
    run_op(16'h0005, 16'h0005, 1'b1, 0, "bin_eq");
    run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 2, "ovf_pos");
  endtask

  task automatic test_backpressure();
    logic [15:0] ez;
    logic        eb;
    logic        eov;
    int          lat;
    model(16'hABCD, 16'h1357, 1'b1, ez, eb, eov);
    in_valid = 1'b1;
    X = 16'hABCD;
    Y = 16'h1357;
    B_in = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        X = 16'h0F0F;
        Y = 16'h0001;
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Z !== ez
          || B_out !== eb || overflow !== eov) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%b/%h/%b/%b exp=1/0/%h/%b/%b",
                 i, out_valid, in_ready, Z, B_out, overflow,
                 ez, eb, eov);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Z !== ez) begin
      failures++;
      $display("FAIL bp_release got=%b/%b/%h exp=1/0/%h",
               in_ready, out_valid, Z, ez);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_reset_busy();
    in_valid = 1'b1;
    X = 16'h4321;
    Y = 16'h1111;
    B_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Z !== 16'h0
        || B_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b/%b/%h/%b/%b exp=1/0/0000/0/0",
               in_ready, out_valid, Z, B_out, overflow);
    end
    run_op(16'h00FF, 16'h000F, 1'b0, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run_op(16'($urandom), 16'($urandom), 1'($urandom),
             $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    B_in      = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
